// File: rtl/seg_scan_driver_if.sv
// Bundle of display data, load strobe and multiplexed LED drive lines.
// The master side supplies digit data; the slave side (the driver) owns seg/dp/an/scan_tick.
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   digits;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic [NUM_DIGITS-1:0]     blink_mask;
   logic [NUM_DIGITS-1:0]     digit_en;
   logic                      lz_blank;
   logic [6:0]                seg;
   logic                      dp;
   logic [NUM_DIGITS-1:0]     an;
   logic                      scan_tick;

   modport master (
      output load, digits, dp_in, blink_mask, digit_en, lz_blank,
      input  seg, dp, an, scan_tick
   );

   modport slave (
      input  load, digits, dp_in, blink_mask, digit_en, lz_blank,
      output seg, dp, an, scan_tick
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: time-slices NUM_DIGITS digits with BCD decode,
// leading-zero blanking, per-digit enable/blink and active-low registered drives.
module seg_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_BITS  = 17,
   parameter int BLINK_BITS = 6
) (
   input  logic               clk,
   input  logic               rst,
   seg_scan_driver_if.slave   bus
);
   localparam int              IDX_W    = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [SCAN_BITS-1:0]  scan_cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [BLINK_BITS-1:0] blink_cnt_q;
   logic                  blink_phase_q;

   logic [3:0]            dig_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] dp_q;
   logic [NUM_DIGITS-1:0] blink_q;
   logic [NUM_DIGITS-1:0] en_q;
   logic                  lz_q;

   logic [6:0]            seg_q;
   logic                  dp_out_q;
   logic [NUM_DIGITS-1:0] an_q;

   logic [6:0]            seg_d;
   logic                  dp_d;
   logic [NUM_DIGITS-1:0] an_d;

   logic                  tick;
   logic [NUM_DIGITS:1]   zero_from;
   logic [NUM_DIGITS-1:0] blank;
   logic [6:0]            seg_dig [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] dp_dig;

   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      case (bcd)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1011000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0011000;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   assign tick = (scan_cnt_q == '1);

   // zero_from[i]: every enabled digit from i upward holds 0; disabled digits pass the chain.
   assign zero_from[NUM_DIGITS] = 1'b1;

   generate
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_chain
         assign zero_from[gi] = zero_from[gi+1] & (~en_q[gi] | (dig_q[gi] == 4'd0));
      end

      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic dark;

         if (gi == 0) begin : g_lsd
            assign blank[gi] = 1'b0;
         end else begin : g_upper
            assign blank[gi] = lz_q & zero_from[gi];
         end

         assign dark        = blink_phase_q & blink_q[gi];
         assign seg_dig[gi] = (~en_q[gi] | blank[gi] | dark) ? 7'b1111111 : seg_decode(dig_q[gi]);
         assign dp_dig[gi]  = (~en_q[gi] | dark) ? 1'b1 : ~dp_q[gi];
      end
   endgenerate

   always_comb begin
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
      an_d  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            seg_d   = seg_dig[i];
            dp_d    = dp_dig[i];
            an_d[i] = ~en_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_q    <= '0;
         idx_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_q[i] <= 4'd0;
         end
         dp_q     <= '0;
         blink_q  <= '0;
         en_q     <= '1;
         lz_q     <= 1'b0;
         seg_q    <= 7'b1111111;
         dp_out_q <= 1'b1;
         an_q     <= '1;
      end else begin
         scan_cnt_q <= scan_cnt_q + SCAN_BITS'(1);
         if (tick) begin
            idx_q       <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            blink_cnt_q <= blink_cnt_q + BLINK_BITS'(1);
            if (blink_cnt_q == '1) begin
               blink_phase_q <= ~blink_phase_q;
            end
         end
         if (bus.load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               dig_q[i] <= bus.digits[4*i +: 4];
            end
            dp_q    <= bus.dp_in;
            blink_q <= bus.blink_mask;
            en_q    <= bus.digit_en;
            lz_q    <= bus.lz_blank;
         end
         seg_q    <= seg_d;
         dp_out_q <= dp_d;
         an_q     <= an_d;
      end
   end

   assign bus.seg       = seg_q;
   assign bus.dp        = dp_out_q;
   assign bus.an        = an_q;
   assign bus.scan_tick = tick & ~rst;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 2..8.
REQ-002 Parameter SCAN_BITS, default 17, width of the refresh divider; one digit period is 2^SCAN_BITS clocks.
REQ-003 Parameter BLINK_BITS, default 6, width of the blink divider counted in scan ticks.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load  input  1  single-cycle strobe; latches digits, dp_in, blink_mask, digit_en, lz_blank into shadow registers.
REQ-007 digits  input  4*NUM_DIGITS  BCD value per digit; digit i at bits [4i+3:4i]; digit 0 least significant.
REQ-008 dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-009 blink_mask  input  NUM_DIGITS  1 = digit blinks.
REQ-010 digit_en  input  NUM_DIGITS  1 = digit enabled; 0 = digit always dark.
REQ-011 lz_blank  input  1  1 = leading-zero blanking enabled.
REQ-012 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
REQ-013 dp  output  1  decimal point drive, active-low, registered.
REQ-014 an  output  NUM_DIGITS  digit anode select, active-low, one-cold, registered.
REQ-015 scan_tick  output  1  one-cycle pulse when the digit index advances.

Function
REQ-016 Scan counter SHALL increment every clock, wrap from 2^SCAN_BITS-1 to 0; scan_tick = 1 in the wrap cycle only.
REQ-017 Digit index SHALL increment on scan_tick, wrapping NUM_DIGITS-1 -> 0 (non-power-of-2 counts skip unused codes).
REQ-018 Blink counter SHALL increment on scan_tick; on its wrap, blink phase toggles; phase 1 darkens digits with blink_mask bit set (seg and dp all 1, an still selected).
REQ-019 Display SHALL use only shadow registers; inputs changing without load SHALL have no effect.
REQ-020 Load taking effect: shadow updates on the load edge; outputs reflect new data on the following edge (1-cycle latency).
REQ-021 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0011000; codes 10-15 = 1111111.
REQ-022 Leading-zero blanking: when lz_blank shadow = 1, digit i SHALL be blank if it and every enabled higher digit hold 0; digit 0 never blanked; disabled digits are ignored in the chain; dp of a blanked digit still honoured.
REQ-023 Disabled digit: an bit for it = 1 during its slot, seg = 1111111, dp = 1; slot timing unchanged.
REQ-024 Enabled, visible digit: an = all 1 except bit index = 0; seg = decode; dp = ~dp_in bit.
REQ-025 Outputs SHALL be registered from current index and shadow state: one-cycle latency from index change to an/seg change.
REQ-026 load coinciding with scan_tick: index advances and shadow updates in the same edge; next digit shows new data.
REQ-027 load coinciding with rst: rst wins, load ignored.

Reset
REQ-028 On rst: scan counter 0, index 0, blink counter 0, blink phase 0, shadow digits 0, dp/blink shadows 0, digit_en shadow all 1, lz_blank shadow 0.
REQ-029 During rst and the edge asserting it: seg = 1111111, dp = 1, an = all 1, scan_tick = 0.
REQ-030 First edge after rst deasserts: an = ...1110, seg = 1000000 (digit 0 shows 0).
REQ-031 rst mid-scan SHALL abandon current slot; no partial state retained.

Verification (NUM_DIGITS=4, SCAN_BITS=2, BLINK_BITS=1)
REQ-032 Reset release, no load -> an cycles 1110,1101,1011,0111 every 4 clocks, seg 1000000 each slot, scan_tick every 4th clock.
REQ-033 load digits=16'h1234 -> slot 0 seg 0011001 (4), slot 3 seg 1111001 (1); digits changed to 16'h9999 without load -> display unchanged.
REQ-034 load digits=16'h0070, lz_blank=1 -> slots 3,2 dark (seg 1111111, an selected), slot 1 = 1011000, slot 0 = 1000000; digits=16'h0000 -> only slot 0 lit.
REQ-035 load blink_mask=4'b0001 -> slot 0 lit for 2 scan ticks' worth of phase 0, dark in phase 1, alternating; other digits steady.
REQ-036 load digit_en=4'b1010, dp_in=4'b0010 -> slots 0,2 an bit stays 1 and seg 1111111; slot 1 dp = 0.
REQ-037 load asserted on scan_tick cycle, and rst asserted mid-slot 2 -> new data on next slot; rst forces all-off then restart at slot 0 with zeros.
